alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that decodes the fetched instruction and produces the ALU command: 3-bit op code plus both 32-bit operands.
- Registers these values, together with the EX/MEM/WB control bits, into the execute stage.
- It is the producer side of the ALU control interface.
- Supports stall (hold), flush (bubble insertion) and a NOOP/illegal path, so the ALU never sees a side-effecting command from an invalid instruction.

Parameters:
- DATA_W, 32, operand width.
- REG_AW, 5, register-address width.

Ports:
- clk_i  in  1  rising-edge clock
- rst_i  in  1  synchronous reset, active-high
- valid_i  in  1  instr_i/rs_data_i/rt_data_i hold a real instruction this cycle
- instr_i  in  32  MIPS instruction word
- rs_data_i  in  DATA_W  register-file read port for rs
- rt_data_i  in  DATA_W  register-file read port for rt
- stall_i  in  1  hold all EX registers
- flush_i  in  1  replace next EX contents with a bubble
- valid_o  out  1  EX stage holds a live instruction
- alu_ctrl_o  out  3  000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR
- data0_o  out  DATA_W  ALU operand A
- data1_o  out  DATA_W  ALU operand B
- store_data_o  out  DATA_W  rt value for sw
- rd_addr_o  out  REG_AW  write-back destination
- reg_write_o  out  1  write-back enable
- mem_read_o  out  1  load
- mem_write_o  out  1  store
- branch_o  out  1  beq
- illegal_o  out  1  registered flag: last loaded instruction was unsupported

Behaviour:
- Reset (rst_i=1 at a clock edge): every output is 0. This includes alu_ctrl_o=000 and data0_o=data1_o=0. Reset wins over flush and stall.
- Update priority at each clock edge: reset > flush > stall > load.
- Flush: loads a bubble in the same edge. A bubble is all outputs 0 and illegal_o=0.
- Stall (without flush): every output holds its value.
- Load: registers the decode of instr_i with 1-cycle latency.
  - If valid_i=0, a bubble is loaded.
- Decode table (opcode = instr[31:26], funct = instr[5:0]):
  - R-type, opcode 000000:
    - funct 100000 add -> ADD
    - funct 100010 sub -> SUB
    - funct 011000 mul -> MUL
    - funct 100100 and -> AND
    - funct 100101 or -> OR
    - In all five cases: data1=rt_data, rd=instr[15:11], reg_write=1.
  - addi, opcode 001000: ADD, data1=sign-extended instr[15:0], rd=instr[20:16], reg_write=1.
  - lw, opcode 100011: ADD, data1=sext imm, rd=instr[20:16], reg_write=1, mem_read=1.
  - sw, opcode 101011: ADD, data1=sext imm, store_data=rt_data, mem_write=1, reg_write=0.
  - beq, opcode 000100: SUB, data1=rt_data, branch=1, reg_write=0.
  - data0 = rs_data in all decoded cases.
- Write suppression: any decoded instruction whose destination is register 0 loads reg_write_o=0.
- NOOP (0x00000000) is treated as a bubble: valid_o=1 with all control bits 0, alu_ctrl_o=000, operands 0, illegal_o=0.
- Any other opcode/funct:
  - valid_o=1, alu_ctrl_o=000, all control bits 0, operands 0, illegal_o=1.
  - illegal_o lasts until the next load, flush or reset.
- Sign extension: bits [31:16] = instr[15]. No other width conversion.
- Deasserted control outputs always read exactly 0.
- Flush and stall in the same cycle: the flush wins and a bubble is loaded.
- Reset mid-stall: the reset clears the stage and the stall is ignored that edge.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst_i=1 with stall_i=1 and an instruction present -> every output is 0 after the edge.
- R-type: rs_data=7, rt_data=5, instr 0x00851020 (add $2,$4,$5), then the same with sub funct 0x22, then mul funct 0x18.
  - Add: the next cycle gives alu_ctrl_o=000, data0_o=7, data1_o=5, rd_addr_o=2, reg_write_o=1.
  - Sub: alu_ctrl_o=001.
  - Mul: alu_ctrl_o=010.
- lw, instr 0x8C82FFFC (lw $2,-4($4)), rs_data=0x100:
  - alu_ctrl_o=000, data0_o=0x100, data1_o=0xFFFFFFFC, mem_read_o=1, reg_write_o=1, rd_addr_o=2.
- sw/beq/writes to $0:
  - sw gives mem_write_o=1, reg_write_o=0, store_data_o=rt_data.
  - beq gives alu_ctrl_o=001, branch_o=1.
  - add $0,$1,$2 gives reg_write_o=0.
- Stall/flush:
  - Load add, then stall_i=1 for 3 cycles while instr_i changes -> outputs unchanged.
  - Then assert stall_i and flush_i together -> bubble, valid_o=0.
- NOOP/illegal:
  - 0x00000000 -> valid_o=1, reg_write_o=0, illegal_o=0.
  - 0xFC000000 -> illegal_o=1, alu_ctrl_o=000, all control bits 0.
  - A following valid add clears illegal_o.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// ALU control interface between the ID/EX issue stage (producer) and the
// execute stage (consumer).
//   master : issue stage, drives every signal
//   slave  : execute stage, samples every signal
// Signals:
//   valid_o      EX stage holds a live instruction
//   alu_ctrl_o   000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR
//   data0_o      ALU operand A
//   data1_o      ALU operand B
//   store_data_o rt value for sw
//   rd_addr_o    write-back destination
//   reg_write_o  write-back enable
//   mem_read_o   load
//   mem_write_o  store
//   branch_o     beq
//   illegal_o    last loaded instruction was unsupported
interface alu_issue_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              valid_o;
   logic [2:0]        alu_ctrl_o;
   logic [DATA_W-1:0] data0_o;
   logic [DATA_W-1:0] data1_o;
   logic [DATA_W-1:0] store_data_o;
   logic [REG_AW-1:0] rd_addr_o;
   logic              reg_write_o;
   logic              mem_read_o;
   logic              mem_write_o;
   logic              branch_o;
   logic              illegal_o;

   modport master (
      output valid_o, alu_ctrl_o, data0_o, data1_o, store_data_o, rd_addr_o,
             reg_write_o, mem_read_o, mem_write_o, branch_o, illegal_o
   );

   modport slave (
      input  valid_o, alu_ctrl_o, data0_o, data1_o, store_data_o, rd_addr_o,
             reg_write_o, mem_read_o, mem_write_o, branch_o, illegal_o
   );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes a MIPS instruction into an ALU command plus
// EX/MEM/WB control bits and registers them into the execute stage.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   valid_i            instr_i / rs_data_i / rt_data_i are live this cycle
//   instr_i            instruction word
//   rs_data_i          register-file read data for rs
//   rt_data_i          register-file read data for rt
//   stall_i            hold the EX registers
//   flush_i            load a bubble (beats stall)
//   ex_o               ALU control interface, producer side
// Every output comes straight from a flop; no input reaches an output
// combinationally.
module alu_issue_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   input  logic [31:0]           instr_i,
   input  logic [DATA_W-1:0]     rs_data_i,
   input  logic [DATA_W-1:0]     rt_data_i,
   input  logic                  stall_i,
   input  logic                  flush_i,
   alu_issue_stage_if.master     ex_o
);

   typedef struct packed {
      logic              valid;
      logic [2:0]        alu_ctrl;
      logic [DATA_W-1:0] data0;
      logic [DATA_W-1:0] data1;
      logic [DATA_W-1:0] store_data;
      logic [REG_AW-1:0] rd_addr;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              branch;
      logic              illegal;
   } ex_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_MUL = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_OR  = 3'b100;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_MUL = 6'b011000;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;

   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic [DATA_W-1:0] imm_sext;
   logic              legal;
   ex_t               dec;
   ex_t               ex_d;
   ex_t               ex_q;

   assign opcode   = instr_i[31:26];
   assign funct    = instr_i[5:0];
   assign imm_sext = {{(DATA_W-16){instr_i[15]}}, instr_i[15:0]};

   // Decode. Unused fields stay 0 so deasserted controls read exactly 0.
   always_comb begin
      dec   = '0;
      legal = 1'b1;
      if (instr_i == 32'h0000_0000) begin
         // NOOP is a live but inert slot
      end else begin
         unique case (opcode)
            OP_RTYPE: begin
               unique case (funct)
                  FN_ADD:  dec.alu_ctrl = ALU_ADD;
                  FN_SUB:  dec.alu_ctrl = ALU_SUB;
                  FN_MUL:  dec.alu_ctrl = ALU_MUL;
                  FN_AND:  dec.alu_ctrl = ALU_AND;
                  FN_OR:   dec.alu_ctrl = ALU_OR;
                  default: legal        = 1'b0;
               endcase
               if (legal) begin
                  dec.data0     = rs_data_i;
                  dec.data1     = rt_data_i;
                  dec.rd_addr   = REG_AW'(instr_i[15:11]);
                  dec.reg_write = 1'b1;
               end
            end
            OP_ADDI: begin
               dec.data0     = rs_data_i;
               dec.data1     = imm_sext;
               dec.rd_addr   = REG_AW'(instr_i[20:16]);
               dec.reg_write = 1'b1;
            end
            OP_LW: begin
               dec.data0     = rs_data_i;
               dec.data1     = imm_sext;
               dec.rd_addr   = REG_AW'(instr_i[20:16]);
               dec.reg_write = 1'b1;
               dec.mem_read  = 1'b1;
            end
            OP_SW: begin
               dec.data0      = rs_data_i;
               dec.data1      = imm_sext;
               dec.store_data = rt_data_i;
               dec.mem_write  = 1'b1;
            end
            OP_BEQ: begin
               dec.alu_ctrl = ALU_SUB;
               dec.data0    = rs_data_i;
               dec.data1    = rt_data_i;
               dec.branch   = 1'b1;
            end
            default: legal = 1'b0;
         endcase
      end
      // $0 is hard-wired zero: never write it back
      if (dec.rd_addr == '0) dec.reg_write = 1'b0;
      if (!legal) dec = '0;
      dec.valid   = 1'b1;
      dec.illegal = !legal;
   end

   // flush > stall > load; reset is applied in the flop
   always_comb begin
      ex_d = ex_q;
      if (flush_i)       ex_d = '0;
      else if (!stall_i) ex_d = valid_i ? dec : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) ex_q <= '0;
      else       ex_q <= ex_d;
   end

   assign ex_o.valid_o      = ex_q.valid;
   assign ex_o.alu_ctrl_o   = ex_q.alu_ctrl;
   assign ex_o.data0_o      = ex_q.data0;
   assign ex_o.data1_o      = ex_q.data1;
   assign ex_o.store_data_o = ex_q.store_data;
   assign ex_o.rd_addr_o    = ex_q.rd_addr;
   assign ex_o.reg_write_o  = ex_q.reg_write;
   assign ex_o.mem_read_o   = ex_q.mem_read;
   assign ex_o.mem_write_o  = ex_q.mem_write;
   assign ex_o.branch_o     = ex_q.branch;
   assign ex_o.illegal_o    = ex_q.illegal;

endmodule
